// File: rtl/hub75_capture.sv
// rtl/hub75_capture.sv - HUB75 bus sink that rebuilds latched lines into a frame-buffer write stream
module hub75_capture #(
    parameter int WIDTH  = 96,
    parameter int HEIGHT = 48,
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sclk,
    input  logic              i_lat,
    input  logic [4:0]        i_row_select,
    input  logic              i_r0,
    input  logic              i_g0,
    input  logic              i_b0,
    input  logic              i_r1,
    input  logic              i_g1,
    input  logic              i_b1,
    input  logic              i_wr_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic [5:0]        o_data,
    output logic              o_frame_done,
    output logic              o_len_err,
    output logic              o_overrun
);

    localparam int ROWS  = HEIGHT / 2;
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int IDX_W = $clog2(2 * WIDTH);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state;
    logic [2:0]        sclk_sync;
    logic [2:0]        lat_sync;
    logic [4:0]        row_s1, row_s2;
    logic [5:0]        dat_s1, dat_s2;
    logic [CNT_W-1:0]  shift_cnt;
    logic              bank_sel;
    logic [4:0]        prev_row;
    logic              rd_bank;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] base;
    logic [5:0]        line_buf [2*WIDTH];

    logic              sclk_rise, lat_rise, len_ok, busy, accept;
    logic              wr_bank, store;
    logic [CNT_W-1:0]  wr_k;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              rd_bank_n;
    logic [COL_W-1:0]  col_n;
    logic [ADDR_W-1:0] base_n;

    // Two-stage synchronisers on every bus pin, plus a third stage on sclk/lat for edge detection
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sclk_sync <= '0;
            lat_sync  <= '0;
            row_s1    <= '0;
            row_s2    <= '0;
            dat_s1    <= '0;
            dat_s2    <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], i_sclk};
            lat_sync  <= {lat_sync[1:0], i_lat};
            row_s1    <= i_row_select;
            row_s2    <= row_s1;
            dat_s1    <= {i_r0, i_g0, i_b0, i_r1, i_g1, i_b1};
            dat_s2    <= dat_s1;
        end
    end

    // Latch qualification and line-buffer write/read indexing
    always_comb begin
        sclk_rise = sclk_sync[1] & ~sclk_sync[2];
        lat_rise  = lat_sync[1] & ~lat_sync[2];
        len_ok    = (shift_cnt == CNT_W'(WIDTH)) && ({1'b0, row_s2} < 6'(ROWS));
        busy      = (state == WRITE);
        accept    = lat_rise && len_ok && !busy;
        // A shift coinciding with a latch starts the next line, in the bank that line will use
        wr_bank   = accept ? ~bank_sel : bank_sel;
        wr_k      = lat_rise ? '0 : shift_cnt;
        store     = sclk_rise && (wr_k < CNT_W'(WIDTH));
        wr_idx    = wr_bank ? (IDX_W'(2 * WIDTH - 1) - IDX_W'(wr_k))
                            : (IDX_W'(WIDTH - 1) - IDX_W'(wr_k));
        rd_bank_n = rd_bank;
        col_n     = (col == COL_W'(WIDTH - 1)) ? col : col + COL_W'(1);
        if (state == IDLE) begin
            rd_bank_n = bank_sel;
            col_n     = '0;
        end
        rd_idx    = rd_bank_n ? (IDX_W'(WIDTH) + IDX_W'(col_n)) : IDX_W'(col_n);
        base_n    = ADDR_W'(32'(row_s2) * WIDTH);
    end

    // Ping-pong line storage; contents need no reset
    always_ff @(posedge i_clk) begin
        if (store) begin
            line_buf[wr_idx] <= dat_s2;
        end
    end

    // Shift counting, bank swapping and the per-latch status pulses
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            shift_cnt    <= '0;
            bank_sel     <= 1'b0;
            prev_row     <= 5'(ROWS - 1);
            o_frame_done <= 1'b0;
            o_len_err    <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            o_len_err    <= 1'b0;
            o_overrun    <= 1'b0;
            if (lat_rise) begin
                shift_cnt <= sclk_rise ? CNT_W'(1) : '0;
                if (!len_ok) begin
                    o_len_err <= 1'b1;
                end else if (busy) begin
                    o_overrun <= 1'b1;
                end else begin
                    bank_sel <= ~bank_sel;
                    prev_row <= row_s2;
                    if (row_s2 < prev_row) begin
                        o_frame_done <= 1'b1;
                    end
                end
            end else if (sclk_rise && (shift_cnt != CNT_W'(WIDTH + 1))) begin
                shift_cnt <= shift_cnt + CNT_W'(1);
            end
        end
    end

    // Writer FSM: streams the filled bank out one column per accepted handshake
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= IDLE;
            o_wr_en <= 1'b0;
            o_addr  <= '0;
            o_data  <= '0;
            col     <= '0;
            rd_bank <= 1'b0;
            base    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= WRITE;
                        o_wr_en <= 1'b1;
                        base    <= base_n;
                        o_addr  <= base_n;
                        col     <= '0;
                        rd_bank <= bank_sel;
                        o_data  <= line_buf[rd_idx];
                    end
                end
                WRITE: begin
                    if (i_wr_ready) begin
                        if (col == COL_W'(WIDTH - 1)) begin
                            state   <= IDLE;
                            o_wr_en <= 1'b0;
                        end else begin
                            col    <= col_n;
                            o_addr <= base + ADDR_W'(col_n);
                            o_data <= line_buf[rd_idx];
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
